// File: rtl/conv_control_gen_pkg.sv
// Shared defaults, FSM state type and width helper for the conv layer control engine.
package conv_control_gen_pkg;

  localparam int unsigned DEF_DATA_WIDTH          = 16;
  localparam int unsigned DEF_INPUT_NUM_MEM       = 6;
  localparam int unsigned DEF_IFMAP_PAR           = 3;
  localparam int unsigned DEF_NUM_ONE_PIXEL_CYCLE = 8;
  localparam int unsigned DEF_PIPE_DELAY          = 4;
  localparam int unsigned DEF_NUM_PIXELS          = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // $clog2 that never returns 0, so single-value selectors still get a 1-bit signal
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/conv_control_gen_group_mux.sv
// Steers one group of PAR feature memories (both ports) onto the MAC lanes; zeros when not enabled.
module conv_group_mux
  import conv_control_gen_pkg::*;
#(
  parameter  int unsigned DW      = 16,
  parameter  int unsigned MEMS    = 6,
  parameter  int unsigned PAR     = 3,
  localparam int unsigned NGROUPS = MEMS / PAR,
  localparam int unsigned GSEL_W  = clog2_min1(NGROUPS)
) (
  input  logic                en,
  input  logic [GSEL_W-1:0]   group_sel,
  input  logic [DW*MEMS-1:0]  q_a_all,
  input  logic [DW*MEMS-1:0]  q_b_all,
  output logic [DW*PAR-1:0]   q_a_mux_all,
  output logic [DW*PAR-1:0]   q_b_mux_all
);

  always_comb begin
    q_a_mux_all = '0;
    q_b_mux_all = '0;
    for (int unsigned g = 0; g < NGROUPS; g++) begin
      if (en && (group_sel == GSEL_W'(g))) begin
        q_a_mux_all = q_a_all[g*PAR*DW +: PAR*DW];
        q_b_mux_all = q_b_all[g*PAR*DW +: PAR*DW];
      end
    end
  end

endmodule

// File: rtl/conv_control_gen.sv
// Conv layer control engine: pipeline fill, per-pixel sload cadence, group round-robin, done flag.
module conv_control_gen
  import conv_control_gen_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH          = DEF_DATA_WIDTH,
  parameter  int unsigned INPUT_NUM_MEM       = DEF_INPUT_NUM_MEM,
  parameter  int unsigned IFMAP_PAR           = DEF_IFMAP_PAR,
  parameter  int unsigned NUM_ONE_PIXEL_CYCLE = DEF_NUM_ONE_PIXEL_CYCLE,
  parameter  int unsigned PIPE_DELAY          = DEF_PIPE_DELAY,
  parameter  int unsigned NUM_PIXELS          = DEF_NUM_PIXELS,
  localparam int unsigned NUM_GROUPS          = INPUT_NUM_MEM / IFMAP_PAR,
  localparam int unsigned GROUP_CYCLES        = NUM_ONE_PIXEL_CYCLE / NUM_GROUPS,
  localparam int unsigned SLOAD_W             = $clog2(NUM_ONE_PIXEL_CYCLE),
  localparam int unsigned PIX_W               = $clog2(NUM_PIXELS + 1),
  localparam int unsigned GSEL_W              = clog2_min1(NUM_GROUPS),
  localparam int unsigned FILL_W              = clog2_min1(PIPE_DELAY)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [DATA_WIDTH*INPUT_NUM_MEM-1:0] in_feature_q_a_all,
  input  logic [DATA_WIDTH*INPUT_NUM_MEM-1:0] in_feature_q_b_all,
  output logic                             in_feature_rden,
  output logic                             weight_rden,
  output logic                             enable_addrger,
  output logic                             enable_mult,
  output logic                             accum_sload,
  output logic [SLOAD_W-1:0]               count_sload,
  output logic [GSEL_W-1:0]                group_sel,
  output logic [DATA_WIDTH*IFMAP_PAR-1:0]  in_feature_q_a_mux_all,
  output logic [DATA_WIDTH*IFMAP_PAR-1:0]  in_feature_q_b_mux_all,
  output logic                             start,
  output logic                             conv_done,
  output logic                             busy
);

  if (((INPUT_NUM_MEM % IFMAP_PAR) != 0) || ((NUM_ONE_PIXEL_CYCLE % NUM_GROUPS) != 0)) begin : g_param_check
    $error("conv_control_gen: INPUT_NUM_MEM must divide by IFMAP_PAR and NUM_ONE_PIXEL_CYCLE by NUM_GROUPS");
  end

  state_t              state_q, state_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [SLOAD_W-1:0]  cnt_q, cnt_d;
  logic [GSEL_W-1:0]   gsel_q, gsel_d;
  logic [PIX_W-1:0]    pix_q, pix_d;
  logic                rden_q, rden_d;
  logic                mult_q, mult_d;
  logic                start_q, start_d;
  logic                done_q, done_d;

  always_comb begin
    state_d = state_q;
    fill_d  = '0;
    cnt_d   = '0;
    pix_d   = '0;
    case (state_q)
      ST_IDLE: if (enable) state_d = ST_FILL;
      ST_FILL: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (fill_q == FILL_W'(PIPE_DELAY - 1)) begin
          state_d = ST_RUN;
        end else begin
          fill_d = fill_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (cnt_q == SLOAD_W'(NUM_ONE_PIXEL_CYCLE - 1)) begin
          if (pix_q == PIX_W'(NUM_PIXELS - 1)) state_d = ST_DONE;
          else                                 pix_d   = pix_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          pix_d = pix_q;
        end
      end
      ST_DONE: if (!enable) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next state
    rden_d  = (state_d == ST_FILL) || (state_d == ST_RUN);
    mult_d  = (state_d == ST_RUN);
    start_d = (state_q == ST_FILL) && (state_d == ST_RUN);
    done_d  = (state_d == ST_DONE);
    gsel_d  = GSEL_W'(32'(cnt_d) / GROUP_CYCLES);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      fill_q  <= '0;
      cnt_q   <= '0;
      gsel_q  <= '0;
      pix_q   <= '0;
      rden_q  <= 1'b0;
      mult_q  <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      gsel_q  <= gsel_d;
      pix_q   <= pix_d;
      rden_q  <= rden_d;
      mult_q  <= mult_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end

  assign in_feature_rden = rden_q;
  assign weight_rden     = rden_q;
  assign enable_addrger  = rden_q;
  assign busy            = rden_q;
  assign enable_mult     = mult_q;
  assign start           = start_q;
  assign conv_done       = done_q;
  assign count_sload     = cnt_q;
  assign group_sel       = gsel_q;
  assign accum_sload     = (state_q == ST_RUN) && (cnt_q == '0);

  conv_group_mux #(
    .DW   (DATA_WIDTH),
    .MEMS (INPUT_NUM_MEM),
    .PAR  (IFMAP_PAR)
  ) u_group_mux (
    .en          (state_q == ST_RUN),
    .group_sel   (gsel_q),
    .q_a_all     (in_feature_q_a_all),
    .q_b_all     (in_feature_q_b_all),
    .q_a_mux_all (in_feature_q_a_mux_all),
    .q_b_mux_all (in_feature_q_b_mux_all)
  );

endmodule

// File: tb/tb_conv_control_gen.sv
// Scoreboard bench for conv_control_gen: default config plus a single-group config on shared stimulus.
module tb_conv_control_gen;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [95:0] mem_a, mem_b;

  always #5 clock = ~clock;

  // default configuration
  logic        a_rden, a_wrden, a_addr, a_mult, a_accum, a_start, a_done, a_busy;
  logic [2:0]  a_cnt;
  logic [0:0]  a_gsel;
  logic [47:0] a_la, a_lb;

  conv_control_gen dut_a (
    .clock(clock), .reset(reset), .enable(enable),
    .in_feature_q_a_all(mem_a), .in_feature_q_b_all(mem_b),
    .in_feature_rden(a_rden), .weight_rden(a_wrden), .enable_addrger(a_addr),
    .enable_mult(a_mult), .accum_sload(a_accum), .count_sload(a_cnt), .group_sel(a_gsel),
    .in_feature_q_a_mux_all(a_la), .in_feature_q_b_mux_all(a_lb),
    .start(a_start), .conv_done(a_done), .busy(a_busy)
  );

  // single group: all six memories pass straight through, 3 cycles per pixel
  logic        b_rden, b_wrden, b_addr, b_mult, b_accum, b_start, b_done, b_busy;
  logic [1:0]  b_cnt;
  logic [0:0]  b_gsel;
  logic [95:0] b_la, b_lb;

  conv_control_gen #(
    .INPUT_NUM_MEM(6), .IFMAP_PAR(6), .NUM_ONE_PIXEL_CYCLE(3)
  ) dut_b (
    .clock(clock), .reset(reset), .enable(enable),
    .in_feature_q_a_all(mem_a), .in_feature_q_b_all(mem_b),
    .in_feature_rden(b_rden), .weight_rden(b_wrden), .enable_addrger(b_addr),
    .enable_mult(b_mult), .accum_sload(b_accum), .count_sload(b_cnt), .group_sel(b_gsel),
    .in_feature_q_a_mux_all(b_la), .in_feature_q_b_mux_all(b_lb),
    .start(b_start), .conv_done(b_done), .busy(b_busy)
  );

  typedef struct packed {
    logic        rden, mult, accum, start, done;
    logic [7:0]  cnt, grp;
    logic [95:0] la, lb;
  } exp_t;

  exp_t qa[$], qb[$];
  int   checks = 0;
  int   errors = 0;
  int   ta = 0, tb = 0;

  // t = cycles since the run began (0 idle, 1..pd fill, then run, then done held)
  function automatic int next_t(int t, logic r, logic e, int pd, int total);
    if (r || !e) return 0;
    return (t + 1 > pd + total + 1) ? pd + total + 1 : t + 1;
  endfunction

  function automatic exp_t model(int t, int pd, int nopc, int npix, int par, int ngroups,
                                 logic [95:0] ma, logic [95:0] mb);
    exp_t r;
    int total = nopc * npix;
    int gc    = nopc / ngroups;
    bit fill  = (t >= 1) && (t <= pd);
    bit run   = (t > pd) && (t <= pd + total);
    int cnt   = run ? (t - pd - 1) % nopc : 0;
    int grp   = cnt / gc;
    r       = '0;
    r.rden  = fill || run;
    r.mult  = run;
    r.accum = run && (cnt == 0);
    r.start = (t == pd + 1);
    r.done  = (t == pd + total + 1);
    r.cnt   = 8'(cnt);
    r.grp   = 8'(grp);
    if (run)
      for (int l = 0; l < par; l++) begin
        r.la[l*16 +: 16] = ma[(grp*par + l)*16 +: 16];
        r.lb[l*16 +: 16] = mb[(grp*par + l)*16 +: 16];
      end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input bit rnd);
    @(negedge clock);
    reset  = r;
    enable = e;
    for (int i = 0; i < 6; i++) begin
      mem_a[i*16 +: 16] = rnd ? 16'($urandom) : 16'(16'h0A00 + i);
      mem_b[i*16 +: 16] = rnd ? 16'($urandom) : 16'(16'h0B00 + i);
    end
    ta = next_t(ta, r, e, 4, 128);
    tb = next_t(tb, r, e, 4, 48);
    qa.push_back(model(ta, 4, 8, 16, 3, 2, mem_a, mem_b));
    qb.push_back(model(tb, 4, 3, 16, 6, 1, mem_a, mem_b));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("a_feature_rden", 96'(a_rden),  96'(e.rden));
        chk("a_weight_rden",  96'(a_wrden), 96'(e.rden));
        chk("a_addrger",      96'(a_addr),  96'(e.rden));
        chk("a_busy",         96'(a_busy),  96'(e.rden));
        chk("a_mult",         96'(a_mult),  96'(e.mult));
        chk("a_accum_sload",  96'(a_accum), 96'(e.accum));
        chk("a_start",        96'(a_start), 96'(e.start));
        chk("a_conv_done",    96'(a_done),  96'(e.done));
        chk("a_count_sload",  96'(a_cnt),   96'(e.cnt));
        chk("a_group_sel",    96'(a_gsel),  96'(e.grp));
        chk("a_lanes_a",      96'(a_la),    e.la);
        chk("a_lanes_b",      96'(a_lb),    e.lb);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("b_feature_rden", 96'(b_rden),  96'(e.rden));
        chk("b_weight_rden",  96'(b_wrden), 96'(e.rden));
        chk("b_addrger",      96'(b_addr),  96'(e.rden));
        chk("b_busy",         96'(b_busy),  96'(e.rden));
        chk("b_mult",         96'(b_mult),  96'(e.mult));
        chk("b_accum_sload",  96'(b_accum), 96'(e.accum));
        chk("b_start",        96'(b_start), 96'(e.start));
        chk("b_conv_done",    96'(b_done),  96'(e.done));
        chk("b_count_sload",  96'(b_cnt),   96'(e.cnt));
        chk("b_group_sel",    96'(b_gsel),  96'(e.grp));
        chk("b_lanes_a",      b_la,         e.la);
        chk("b_lanes_b",      b_lb,         e.lb);
      end
    end
  end

  initial begin : stimulus
    int len, gap;
    reset  = 1'b1;
    enable = 1'b0;
    mem_a  = '0;
    mem_b  = '0;
    repeat (3) step(1'b1, 1'b0, 1'b0);
    // full run with patterned memories, done held, then released
    repeat (145) step(1'b0, 1'b1, 1'b0);
    repeat (2)   step(1'b0, 1'b0, 1'b0);
    // abort at pixel 7 cycle 3 of the default config, then a complete rerun
    repeat (64)  step(1'b0, 1'b1, 1'b0);
    repeat (3)   step(1'b0, 1'b0, 1'b0);
    repeat (140) step(1'b0, 1'b1, 1'b0);
    repeat (2)   step(1'b0, 1'b0, 1'b0);
    // one-cycle reset mid-run with enable held
    repeat (30)  step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    repeat (150) step(1'b0, 1'b1, 1'b1);
    // done released and re-requested on the next cycle
    step(1'b0, 1'b0, 1'b1);
    repeat (20)  step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    // random enable bursts, occasional reset, random memory data
    for (int b = 0; b < 25; b++) begin
      len = $urandom_range(1, 200);
      gap = $urandom_range(1, 4);
      for (int c = 0; c < len; c++) step(($urandom_range(0, 299) == 0), 1'b1, 1'b1);
      for (int c = 0; c < gap; c++) step(1'b0, 1'b0, 1'b1);
    end
    repeat (3) @(negedge clock);
    chk("scoreboard_drain", 96'(qa.size() + qb.size()), 96'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
